// File: rtl/sobel_conv_scheduler.sv
// Shares one sobel_matrix_conv between the Gx and Gy kernels of a 3x3 window and
// returns the saturated |Gx|+|Gy| magnitude over a valid/ready handshake.
module sobel_conv_scheduler #(
  parameter int DATA_SIZE = 24,
  parameter int CONV_W    = 29,
  parameter int MAG_W     = 30,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 win_valid,
  output logic                 win_ready,
  input  logic [DATA_SIZE-1:0] w00,
  input  logic [DATA_SIZE-1:0] w01,
  input  logic [DATA_SIZE-1:0] w02,
  input  logic [DATA_SIZE-1:0] w10,
  input  logic [DATA_SIZE-1:0] w12,
  input  logic [DATA_SIZE-1:0] w20,
  input  logic [DATA_SIZE-1:0] w21,
  input  logic [DATA_SIZE-1:0] w22,
  output logic                 conv_valid,
  output logic [DATA_SIZE-1:0] conv_p1a,
  output logic [DATA_SIZE-1:0] conv_p2,
  output logic [DATA_SIZE-1:0] conv_p1b,
  output logic [DATA_SIZE-1:0] conv_m1a,
  output logic [DATA_SIZE-1:0] conv_m2,
  output logic [DATA_SIZE-1:0] conv_m1b,
  input  logic                 conv_rdy,
  input  logic [CONV_W-1:0]    conv_data,
  output logic                 mag_valid,
  input  logic                 mag_ready,
  output logic [MAG_W-1:0]     mag,
  output logic                 err,
  output logic [CNT_W-1:0]     win_cnt
);

  // state   | meaning
  // IDLE    | waiting for a window; win_ready high
  // ISSUE_X | Gx operands on the conv inputs
  // ISSUE_Y | Gy operands on the conv inputs; Gx result expected
  // WAIT_Y  | conv inputs idle; Gy result expected
  // OUTPUT  | magnitude presented until mag_ready
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_X = 3'd1,
    ISSUE_Y = 3'd2,
    WAIT_Y  = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

  localparam int SUM_W = CONV_W + 1;
  localparam int EXT_W = (MAG_W > SUM_W) ? MAG_W : SUM_W;
  localparam logic [CONV_W-1:0] CONV_ONE = CONV_W'(1);
  localparam logic [EXT_W-1:0]  MAG_MAX  = EXT_W'({MAG_W{1'b1}});

  state_t              state;
  // Gx operands go out straight from the inputs on accept, so only the
  // pixels needed for the Gy issue are kept.
  logic [DATA_SIZE-1:0] r00, r01, r02, r20, r21, r22;
  logic [CONV_W-1:0]    gx_q;

  logic [CONV_W-1:0] gx_abs, gy_abs;
  logic [SUM_W-1:0]  sum;
  logic [EXT_W-1:0]  sum_ext;
  logic [MAG_W-1:0]  mag_next;

  // The most negative input maps to 2^(CONV_W-1), still representable unsigned.
  function automatic logic [CONV_W-1:0] abs_val(input logic [CONV_W-1:0] x);
    return x[CONV_W-1] ? ((~x) + CONV_ONE) : x;
  endfunction

  assign win_ready = (state == IDLE);

  always_comb begin
    gx_abs   = abs_val(gx_q);
    gy_abs   = abs_val(conv_data);
    sum      = {1'b0, gx_abs} + {1'b0, gy_abs};
    sum_ext  = EXT_W'(sum);
    mag_next = (sum_ext > MAG_MAX) ? {MAG_W{1'b1}} : sum_ext[MAG_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      r00        <= '0;
      r01        <= '0;
      r02        <= '0;
      r20        <= '0;
      r21        <= '0;
      r22        <= '0;
      gx_q       <= '0;
      conv_valid <= 1'b0;
      conv_p1a   <= '0;
      conv_p2    <= '0;
      conv_p1b   <= '0;
      conv_m1a   <= '0;
      conv_m2    <= '0;
      conv_m1b   <= '0;
      mag_valid  <= 1'b0;
      mag        <= '0;
      err        <= 1'b0;
      win_cnt    <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            r00        <= w00;
            r01        <= w01;
            r02        <= w02;
            r20        <= w20;
            r21        <= w21;
            r22        <= w22;
            conv_valid <= 1'b1;
            conv_p1a   <= w02;
            conv_p2    <= w12;
            conv_p1b   <= w22;
            conv_m1a   <= w00;
            conv_m2    <= w10;
            conv_m1b   <= w20;
            state      <= ISSUE_X;
          end
        end
        ISSUE_X: begin
          conv_valid <= 1'b1;
          conv_p1a   <= r20;
          conv_p2    <= r21;
          conv_p1b   <= r22;
          conv_m1a   <= r00;
          conv_m2    <= r01;
          conv_m1b   <= r02;
          state      <= ISSUE_Y;
        end
        ISSUE_Y: begin
          conv_valid <= 1'b0;
          conv_p1a   <= '0;
          conv_p2    <= '0;
          conv_p1b   <= '0;
          conv_m1a   <= '0;
          conv_m2    <= '0;
          conv_m1b   <= '0;
          if (conv_rdy) begin
            gx_q  <= conv_data;
            state <= WAIT_Y;
          end else begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        WAIT_Y: begin
          if (conv_rdy) begin
            mag       <= mag_next;
            mag_valid <= 1'b1;
            state     <= OUTPUT;
          end else begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        OUTPUT: begin
          if (mag_ready) begin
            mag_valid <= 1'b0;
            win_cnt   <= win_cnt + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_conv_scheduler.sv
// Bench for sobel_conv_scheduler: fixed vectors, hand sequences for stall/error/reset,
// and random windows checked against a plain-arithmetic Sobel magnitude model.
module tb_sobel_conv_scheduler;

  localparam int DS = 24;
  localparam int CW = 29;

  typedef struct packed {
    logic [DS-1:0] w00, w01, w02, w10, w12, w20, w21, w22;
  } win_t;

  typedef struct {
    string  nm;
    win_t   w;
    longint mag;
    longint mag8;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic win_valid = 1'b0;
  logic mag_ready = 1'b0;
  logic [DS-1:0] w00 = '0, w01 = '0, w02 = '0, w10 = '0, w12 = '0, w20 = '0, w21 = '0, w22 = '0;
  logic win_ready, conv_valid, mag_valid, err;
  logic [DS-1:0] conv_p1a, conv_p2, conv_p1b, conv_m1a, conv_m2, conv_m1b;
  logic conv_rdy;
  logic [CW-1:0] conv_data;
  logic [29:0] mag;
  logic [15:0] win_cnt;

  logic win_ready8, conv_valid8, mag_valid8, err8;
  logic [DS-1:0] c8_p1a, c8_p2, c8_p1b, c8_m1a, c8_m2, c8_m1b;
  logic [7:0] mag8;
  logic [15:0] win_cnt8;

  logic [1:0] drop_mask = 2'b00;
  logic ovr_en = 1'b0;
  logic prev_cv;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  sobel_conv_scheduler dut (
    .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .win_ready(win_ready),
    .w00(w00), .w01(w01), .w02(w02), .w10(w10), .w12(w12), .w20(w20), .w21(w21), .w22(w22),
    .conv_valid(conv_valid), .conv_p1a(conv_p1a), .conv_p2(conv_p2), .conv_p1b(conv_p1b),
    .conv_m1a(conv_m1a), .conv_m2(conv_m2), .conv_m1b(conv_m1b),
    .conv_rdy(conv_rdy), .conv_data(conv_data), .mag_valid(mag_valid), .mag_ready(mag_ready),
    .mag(mag), .err(err), .win_cnt(win_cnt)
  );

  sobel_conv_scheduler #(.MAG_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .win_ready(win_ready8),
    .w00(w00), .w01(w01), .w02(w02), .w10(w10), .w12(w12), .w20(w20), .w21(w21), .w22(w22),
    .conv_valid(conv_valid8), .conv_p1a(c8_p1a), .conv_p2(c8_p2), .conv_p1b(c8_p1b),
    .conv_m1a(c8_m1a), .conv_m2(c8_m2), .conv_m1b(c8_m1b),
    .conv_rdy(conv_rdy), .conv_data(conv_data), .mag_valid(mag_valid8), .mag_ready(mag_ready),
    .mag(mag8), .err(err8), .win_cnt(win_cnt8)
  );

  // Convolution engine stand-in: one-cycle latency, result = sum(p) - sum(m) with centre weight 2.
  function automatic logic [CW-1:0] conv_fn(input logic [DS-1:0] a, b, c, d, e, f);
    longint v;
    v = longint'(a) + 2 * longint'(b) + longint'(c) - longint'(d) - 2 * longint'(e) - longint'(f);
    return v[CW-1:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_rdy  <= 1'b0;
      conv_data <= '0;
      prev_cv   <= 1'b0;
    end else begin
      prev_cv   <= conv_valid;
      conv_rdy  <= conv_valid && !(prev_cv ? drop_mask[1] : drop_mask[0]);
      conv_data <= ovr_en ? {1'b1, {(CW-1){1'b0}}}
                          : conv_fn(conv_p1a, conv_p2, conv_p1b, conv_m1a, conv_m2, conv_m1b);
    end
  end

  function automatic longint iabs(input longint x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic longint ref_mag(input win_t w, input longint cap);
    longint gx, gy, s;
    gx = (longint'(w.w02) + 2 * longint'(w.w12) + longint'(w.w22))
       - (longint'(w.w00) + 2 * longint'(w.w10) + longint'(w.w20));
    gy = (longint'(w.w20) + 2 * longint'(w.w21) + longint'(w.w22))
       - (longint'(w.w00) + 2 * longint'(w.w01) + longint'(w.w02));
    s = iabs(gx) + iabs(gy);
    return (s > cap) ? cap : s;
  endfunction

  function automatic win_t mk(input longint a00, a01, a02, a10, a12, a20, a21, a22);
    win_t w;
    w.w00 = DS'(a00); w.w01 = DS'(a01); w.w02 = DS'(a02); w.w10 = DS'(a10);
    w.w12 = DS'(a12); w.w20 = DS'(a20); w.w21 = DS'(a21); w.w22 = DS'(a22);
    return w;
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_win(input win_t w);
    w00 = w.w00; w01 = w.w01; w02 = w.w02; w10 = w.w10;
    w12 = w.w12; w20 = w.w20; w21 = w.w21; w22 = w.w22;
  endtask

  function automatic logic [159:0] ops_now();
    return 160'({conv_p1a, conv_p2, conv_p1b, conv_m1a, conv_m2, conv_m1b});
  endfunction

  function automatic logic [159:0] ops_gx(input win_t w);
    return 160'({w.w02, w.w12, w.w22, w.w00, w.w10, w.w20});
  endfunction

  function automatic logic [159:0] ops_gy(input win_t w);
    return 160'({w.w20, w.w21, w.w22, w.w00, w.w01, w.w02});
  endfunction

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!win_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready"}, 160'(win_ready), 160'(1));
  endtask

  // One window from accept to handshake; stall = cycles of mag_ready low in OUTPUT,
  // drop[0]/drop[1] suppress the Gx/Gy conv response.
  task automatic run_window(input string nm, input win_t w, input longint em, input longint em8,
                            input int stall, input logic [1:0] drop);
    @(negedge clk);
    set_win(w);
    win_valid = 1'b1;
    mag_ready = (stall == 0);
    drop_mask = drop;
    wait_ready(nm);
    @(posedge clk);
    @(negedge clk);
    win_valid = 1'b0;
    chk({nm, "_cv_x"}, 160'(conv_valid), 160'(1));
    chk({nm, "_ops_x"}, ops_now(), ops_gx(w));
    @(negedge clk);
    chk({nm, "_cv_y"}, 160'(conv_valid), 160'(1));
    chk({nm, "_ops_y"}, ops_now(), ops_gy(w));
    @(negedge clk);
    if (drop[0]) begin
      chk({nm, "_err_x"}, 160'({err, conv_valid, win_ready, mag_valid}), 160'(4'b1010));
      @(negedge clk);
      chk({nm, "_err_x_clr"}, 160'({err, mag_valid, win_cnt}), 160'({2'b00, exp_cnt}));
      drop_mask = 2'b00;
      return;
    end
    chk({nm, "_wait"}, 160'({conv_valid, mag_valid, ops_now()}), 160'(0));
    @(negedge clk);
    if (drop[1]) begin
      chk({nm, "_err_y"}, 160'({err, win_ready, mag_valid}), 160'(3'b110));
      @(negedge clk);
      chk({nm, "_err_y_clr"}, 160'({err, mag_valid, win_cnt}), 160'({2'b00, exp_cnt}));
      drop_mask = 2'b00;
      return;
    end
    chk({nm, "_mag"}, 160'({mag_valid, mag}), 160'({1'b1, 30'(em)}));
    chk({nm, "_mag8"}, 160'({mag_valid8, mag8}), 160'({1'b1, 8'(em8)}));
    chk({nm, "_busy"}, 160'(win_ready), 160'(0));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({nm, "_stall"}, 160'({mag_valid, mag, win_ready, win_cnt}),
          160'({1'b1, 30'(em), 1'b0, exp_cnt}));
    end
    mag_ready = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    chk({nm, "_done"}, 160'({mag_valid, win_ready, win_cnt}), 160'({2'b01, exp_cnt}));
    if (stall > 0) begin
      @(negedge clk);
      chk({nm, "_once"}, 160'(win_cnt), 160'(exp_cnt));
    end
  endtask

  initial begin
    vec_t vecs[6];
    win_t a, b;
    longint cap30;
    cap30 = (longint'(1) << 30) - 1;
    vecs[0] = '{"flat",   mk(100, 100, 100, 100, 100, 100, 100, 100), 0, 0};
    vecs[1] = '{"lr_edge", mk(0, 0, 10, 0, 10, 0, 0, 10), 40, 40};
    vecs[2] = '{"top50",  mk(50, 50, 50, 0, 0, 0, 0, 0), 200, 200};
    vecs[3] = '{"sat8",   mk(100, 0, 0, 50, 0, 0, 100, 0), 300, 255};
    vecs[4] = '{"br7",    mk(0, 0, 0, 0, 0, 0, 0, 7), 14, 14};
    vecs[5] = '{"maxpix", mk(0, 0, 16777215, 0, 16777215, 0, 16777215, 16777215), 100663290, 255};

    #2 rst_n = 1'b0;
    #3;
    chk("reset_state", 160'({conv_valid, mag_valid, err, mag, win_cnt, ops_now()}), 160'(0));
    chk("reset_ready", 160'(win_ready), 160'(1));
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", 160'(win_ready), 160'(1));

    for (int i = 0; i < 6; i++)
      run_window(vecs[i].nm, vecs[i].w, vecs[i].mag, vecs[i].mag8, 0, 2'b00);

    run_window("stall6", vecs[2].w, 200, 200, 6, 2'b00);
    run_window("drop_x", vecs[1].w, 0, 0, 0, 2'b01);
    run_window("drop_y", vecs[1].w, 0, 0, 0, 2'b10);
    run_window("after_err", vecs[1].w, 40, 40, 0, 2'b00);

    ovr_en = 1'b1;
    run_window("most_neg", vecs[0].w, longint'(1) << 29, 255, 0, 2'b00);
    ovr_en = 1'b0;

    // win_valid held high: pixels changed while busy must not disturb the first window.
    a = mk(1, 2, 3, 4, 5, 6, 7, 8);
    b = mk(9000, 10, 0, 300, 7, 0, 5000, 1);
    @(negedge clk);
    set_win(a);
    win_valid = 1'b1;
    mag_ready = 1'b1;
    wait_ready("b2b");
    @(posedge clk);
    @(negedge clk);
    set_win(b);
    @(negedge clk);
    chk("b2b_ops_y_a", ops_now(), ops_gy(a));
    @(negedge clk);
    @(negedge clk);
    chk("b2b_mag_a", 160'({mag_valid, mag}), 160'({1'b1, 30'(ref_mag(a, cap30))}));
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    chk("b2b_idle", 160'({win_ready, mag_valid, win_cnt}), 160'({2'b10, exp_cnt}));
    @(negedge clk);
    win_valid = 1'b0;
    chk("b2b_ops_x_b", 160'({conv_valid, ops_now()}), 160'({1'b1, ops_gx(b)}));
    repeat (3) @(negedge clk);
    chk("b2b_mag_b", 160'({mag_valid, mag}), 160'({1'b1, 30'(ref_mag(b, cap30))}));
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    chk("b2b_cnt", 160'(win_cnt), 160'(exp_cnt));

    // Async reset while in ISSUE_Y.
    @(negedge clk);
    set_win(vecs[3].w);
    win_valid = 1'b1;
    wait_ready("rst_mid");
    @(posedge clk);
    @(negedge clk);
    win_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_mid_outs", 160'({conv_valid, mag_valid, err, mag, win_cnt, ops_now()}), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    #1 chk("rst_mid_ready", 160'(win_ready), 160'(1));
    run_window("post_rst", vecs[3].w, 300, 255, 0, 2'b00);

    for (int i = 0; i < 20; i++) begin
      a = mk($urandom & 24'hFFFFFF, $urandom & 24'hFFFFFF, $urandom & 24'hFFFFFF,
             $urandom & 24'hFFFFFF, $urandom & 24'hFFFFFF, $urandom & 24'hFFFFFF,
             $urandom & 24'hFFFFFF, $urandom & 24'hFFFFFF);
      if (i % 4 == 1) a = mk($urandom_range(0, 99), $urandom_range(0, 99), $urandom_range(0, 99),
                             $urandom_range(0, 99), $urandom_range(0, 99), $urandom_range(0, 99),
                             $urandom_range(0, 99), $urandom_range(0, 99));
      run_window("rand", a, ref_mag(a, cap30), ref_mag(a, 255), (i % 5 == 2) ? 2 : 0, 2'b00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
